// File: rtl/mem_bus_bridge.sv
// Bridge between the 8227 core bus and a req/ack external memory port.
// Reads stall the core via ready; writes are posted to a FIFO and drained ahead of reads.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        busCycleStart,
    input  logic [7:0]  cpuAddrHigh,
    input  logic [7:0]  cpuAddrLow,
    input  logic        cpuReadNotWrite,
    input  logic [7:0]  cpuDataOut,
    output logic [7:0]  cpuDataIn,
    output logic        ready,
    output logic        memReq,
    output logic        memWrite,
    output logic [15:0] memAddr,
    output logic [7:0]  memWdata,
    input  logic [7:0]  memRdata,
    input  logic        memAck,
    output logic        busError,
    output logic        writeOverrun,
    input  logic        clearErrors
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WREQ, RREQ, GAP} stateT;

    stateT            state;
    logic [15:0]      fifoAddr [FIFO_DEPTH];
    logic [7:0]       fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   fifoCount;
    logic [15:0]      readAddr;
    logic             readPending;
    logic [7:0]       toCount;

    logic cpuWrite;
    logic cpuRead;
    logic fifoFull;
    logic fifoEmpty;
    logic lastCycle;
    logic pop;
    logic push;
    logic drop;
    logic timeoutNow;

    always_comb begin
        cpuWrite   = busCycleStart & ~readPending & ~cpuReadNotWrite;
        cpuRead    = busCycleStart & ~readPending & cpuReadNotWrite;
        fifoFull   = (fifoCount == DEPTH_CNT);
        fifoEmpty  = (fifoCount == '0);
        lastCycle  = (toCount == LAST_COUNT);
        // Ack on the final allowed cycle takes precedence over the timeout.
        pop        = (state == WREQ) & (memAck | lastCycle);
        push       = cpuWrite & (~fifoFull | pop);
        drop       = cpuWrite & fifoFull & ~pop;
        timeoutNow = ((state == WREQ) | (state == RREQ)) & ~memAck & lastCycle;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= {cpuAddrHigh, cpuAddrLow};
            fifoData[wrPtr] <= cpuDataOut;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            wrPtr        <= '0;
            rdPtr        <= '0;
            fifoCount    <= '0;
            readAddr     <= '0;
            readPending  <= 1'b0;
            toCount      <= '0;
            cpuDataIn    <= 8'h00;
            ready        <= 1'b1;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddr      <= '0;
            memWdata     <= '0;
            busError     <= 1'b0;
            writeOverrun <= 1'b0;
        end else begin
            busError     <= (busError & ~clearErrors) | timeoutNow;
            writeOverrun <= (writeOverrun & ~clearErrors) | drop;

            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase

            if (cpuRead) begin
                readAddr    <= {cpuAddrHigh, cpuAddrLow};
                readPending <= 1'b1;
                ready       <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!fifoEmpty) begin
                        state    <= WREQ;
                        memReq   <= 1'b1;
                        memWrite <= 1'b1;
                        memAddr  <= fifoAddr[rdPtr];
                        memWdata <= fifoData[rdPtr];
                        toCount  <= '0;
                    end else if (readPending) begin
                        state    <= RREQ;
                        memReq   <= 1'b1;
                        memWrite <= 1'b0;
                        memAddr  <= readAddr;
                        toCount  <= '0;
                    end
                end
                WREQ: begin
                    if (memAck || lastCycle) begin
                        state    <= GAP;
                        memReq   <= 1'b0;
                        memWrite <= 1'b0;
                    end else begin
                        toCount <= toCount + 1'b1;
                    end
                end
                RREQ: begin
                    if (memAck || lastCycle) begin
                        state       <= GAP;
                        memReq      <= 1'b0;
                        cpuDataIn   <= memAck ? memRdata : 8'hFF;
                        readPending <= 1'b0;
                        ready       <= 1'b1;
                    end else begin
                        toCount <= toCount + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: reads, posted writes, ordering, timeouts, sticky errors.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        nrst;
    logic        busCycleStart;
    logic [7:0]  cpuAddrHigh;
    logic [7:0]  cpuAddrLow;
    logic        cpuReadNotWrite;
    logic [7:0]  cpuDataOut;
    logic [7:0]  cpuDataIn;
    logic        ready;
    logic        memReq;
    logic        memWrite;
    logic [15:0] memAddr;
    logic [7:0]  memWdata;
    logic [7:0]  memRdata;
    logic        memAck;
    logic        busError;
    logic        writeOverrun;
    logic        clearErrors;

    int testsRun    = 0;
    int testsFailed = 0;
    int hi;

    mem_bus_bridge #(.TIMEOUT_CYCLES(15), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .busCycleStart  (busCycleStart),
        .cpuAddrHigh    (cpuAddrHigh),
        .cpuAddrLow     (cpuAddrLow),
        .cpuReadNotWrite(cpuReadNotWrite),
        .cpuDataOut     (cpuDataOut),
        .cpuDataIn      (cpuDataIn),
        .ready          (ready),
        .memReq         (memReq),
        .memWrite       (memWrite),
        .memAddr        (memAddr),
        .memWdata       (memWdata),
        .memRdata       (memRdata),
        .memAck         (memAck),
        .busError       (busError),
        .writeOverrun   (writeOverrun),
        .clearErrors    (clearErrors)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuCycle(input logic rnw, input logic [15:0] addr, input logic [7:0] data);
        busCycleStart   = 1'b1;
        cpuReadNotWrite = rnw;
        cpuAddrHigh     = addr[15:8];
        cpuAddrLow      = addr[7:0];
        cpuDataOut      = data;
        tick();
        busCycleStart   = 1'b0;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!memReq && n < 40) begin
            tick();
            n++;
        end
        checkVal(tag, {31'd0, memReq}, 32'd1);
    endtask

    // Counts cycles memReq stays high; hi must already hold the samples seen so far.
    task automatic countHigh();
        int guard = 0;
        while (memReq && guard < 60) begin
            tick();
            guard++;
            if (memReq) hi++;
        end
    endtask

    initial begin
        nrst = 1'b0;
        busCycleStart = 1'b0;
        cpuAddrHigh = '0;
        cpuAddrLow = '0;
        cpuReadNotWrite = 1'b1;
        cpuDataOut = '0;
        memRdata = '0;
        memAck = 1'b0;
        clearErrors = 1'b0;

        // Reset state
        repeat (3) tick();
        checkVal("rst ready", {31'd0, ready}, 32'd1);
        checkVal("rst memReq", {31'd0, memReq}, 32'd0);
        checkVal("rst cpuDataIn", {24'd0, cpuDataIn}, 32'h00);
        checkVal("rst memAddr", {16'd0, memAddr}, 32'h0000);
        checkVal("rst busError", {31'd0, busError}, 32'd0);
        checkVal("rst overrun", {31'd0, writeOverrun}, 32'd0);
        nrst = 1'b1;
        repeat (2) tick();

        // Read 0x1234, ack two cycles after memReq
        cpuCycle(1'b1, 16'h1234, 8'h00);
        checkVal("rd1 ready low", {31'd0, ready}, 32'd0);
        waitReq("rd1 req");
        checkVal("rd1 addr", {16'd0, memAddr}, 32'h1234);
        checkVal("rd1 memWrite", {31'd0, memWrite}, 32'd0);
        tick();
        checkVal("rd1 ready wait", {31'd0, ready}, 32'd0);
        memAck = 1'b1;
        memRdata = 8'hA5;
        tick();
        memAck = 1'b0;
        checkVal("rd1 data", {24'd0, cpuDataIn}, 32'hA5);
        checkVal("rd1 ready", {31'd0, ready}, 32'd1);
        checkVal("rd1 gap", {31'd0, memReq}, 32'd0);
        tick();
        checkVal("rd1 idle", {31'd0, memReq}, 32'd0);
        tick();

        // Write then read same address: write drains first
        cpuCycle(1'b0, 16'h0200, 8'h11);
        tick();
        checkVal("wr2 req", {31'd0, memReq}, 32'd1);
        checkVal("wr2 memWrite", {31'd0, memWrite}, 32'd1);
        checkVal("wr2 addr", {16'd0, memAddr}, 32'h0200);
        checkVal("wr2 wdata", {24'd0, memWdata}, 32'h11);
        cpuCycle(1'b1, 16'h0200, 8'h00);
        checkVal("wr2 rd ready", {31'd0, ready}, 32'd0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkVal("wr2 done req", {31'd0, memReq}, 32'd0);
        checkVal("wr2 ready held", {31'd0, ready}, 32'd0);
        waitReq("rd2 req");
        checkVal("rd2 memWrite", {31'd0, memWrite}, 32'd0);
        checkVal("rd2 addr", {16'd0, memAddr}, 32'h0200);
        checkVal("rd2 ready", {31'd0, ready}, 32'd0);
        memAck = 1'b1;
        memRdata = 8'h11;
        tick();
        memAck = 1'b0;
        checkVal("rd2 data", {24'd0, cpuDataIn}, 32'h11);
        checkVal("rd2 ready done", {31'd0, ready}, 32'd1);
        repeat (2) tick();

        // Three writes, no ack: overrun, then timeout on the first
        cpuCycle(1'b0, 16'h0300, 8'hAA);
        tick();
        cpuCycle(1'b0, 16'h0301, 8'hBB);
        tick();
        cpuCycle(1'b0, 16'h0302, 8'hCC);
        checkVal("ovr flag", {31'd0, writeOverrun}, 32'd1);
        checkVal("ovr head addr", {16'd0, memAddr}, 32'h0300);
        checkVal("ovr no buserr", {31'd0, busError}, 32'd0);
        hi = 4;
        countHigh();
        checkVal("wr timeout len", hi, 32'd15);
        checkVal("wr timeout err", {31'd0, busError}, 32'd1);
        waitReq("wr second req");
        checkVal("wr second addr", {16'd0, memAddr}, 32'h0301);
        checkVal("wr second data", {24'd0, memWdata}, 32'hBB);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkVal("wr second done", {31'd0, memReq}, 32'd0);
        repeat (3) tick();
        checkVal("wr third dropped", {31'd0, memReq}, 32'd0);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        checkVal("clr busError", {31'd0, busError}, 32'd0);
        checkVal("clr overrun", {31'd0, writeOverrun}, 32'd0);
        tick();

        // Read timeout
        cpuCycle(1'b1, 16'h0400, 8'h00);
        waitReq("rto req");
        hi = 1;
        countHigh();
        checkVal("rto len", hi, 32'd15);
        checkVal("rto data", {24'd0, cpuDataIn}, 32'hFF);
        checkVal("rto ready", {31'd0, ready}, 32'd1);
        checkVal("rto busError", {31'd0, busError}, 32'd1);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        checkVal("rto cleared", {31'd0, busError}, 32'd0);
        tick();

        // clearErrors on the same cycle as a fresh timeout
        memRdata = 8'h77;
        cpuCycle(1'b1, 16'h0410, 8'h00);
        waitReq("clrto req");
        repeat (14) tick();
        checkVal("clrto still req", {31'd0, memReq}, 32'd1);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        checkVal("clrto err wins", {31'd0, busError}, 32'd1);
        checkVal("clrto req off", {31'd0, memReq}, 32'd0);
        checkVal("clrto data", {24'd0, cpuDataIn}, 32'hFF);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        tick();

        // Ack on exactly the timeout cycle counts as success
        cpuCycle(1'b1, 16'h0500, 8'h00);
        waitReq("edge req");
        repeat (14) tick();
        memAck = 1'b1;
        memRdata = 8'h5A;
        tick();
        memAck = 1'b0;
        checkVal("edge data", {24'd0, cpuDataIn}, 32'h5A);
        checkVal("edge busError", {31'd0, busError}, 32'd0);
        checkVal("edge ready", {31'd0, ready}, 32'd1);
        repeat (2) tick();

        // Minimum read latency; ack held high while still IDLE must be ignored
        cpuCycle(1'b1, 16'h0600, 8'h00);
        memAck = 1'b1;
        memRdata = 8'hC3;
        checkVal("lat c1 ready", {31'd0, ready}, 32'd0);
        tick();
        checkVal("lat c2 ready", {31'd0, ready}, 32'd0);
        checkVal("lat c2 req", {31'd0, memReq}, 32'd1);
        tick();
        memAck = 1'b0;
        checkVal("lat c3 ready", {31'd0, ready}, 32'd1);
        checkVal("lat c3 data", {24'd0, cpuDataIn}, 32'hC3);
        repeat (2) tick();

        // Asynchronous reset during RREQ
        cpuCycle(1'b1, 16'h0700, 8'h00);
        waitReq("arst req");
        #3;
        nrst = 1'b0;
        #1;
        checkVal("arst memReq", {31'd0, memReq}, 32'd0);
        checkVal("arst ready", {31'd0, ready}, 32'd1);
        checkVal("arst memAddr", {16'd0, memAddr}, 32'h0000);
        checkVal("arst cpuDataIn", {24'd0, cpuDataIn}, 32'h00);
        tick();
        nrst = 1'b1;
        repeat (2) tick();
        checkVal("post arst req", {31'd0, memReq}, 32'd0);
        checkVal("post arst ready", {31'd0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
